// File: rtl/freq_gate_gen_if.sv
// freq_gate_gen_if: control and status bundle between a measurement controller and freq_gate_gen
interface freq_gate_gen_if #(
    parameter int CNT_W = 32,
    parameter int SEQ_W = 16
);
    logic             start;
    logic             continuous;
    logic             abort;
    logic [CNT_W-1:0] window_len;
    logic             en_sample;
    logic             busy;
    logic             meas_done;
    logic [CNT_W-1:0] window_cycles;
    logic [SEQ_W-1:0] meas_seq;
    logic             err_zero_len;

    modport master (
        output start, continuous, abort, window_len,
        input  en_sample, busy, meas_done, window_cycles, meas_seq, err_zero_len
    );
    modport slave (
        input  start, continuous, abort, window_len,
        output en_sample, busy, meas_done, window_cycles, meas_seq, err_zero_len
    );
endinterface

// File: rtl/freq_gate_gen.sv
// freq_gate_gen: programmable-length measurement gate with settle interval and completion pulse
module freq_gate_gen #(
    parameter int CNT_W         = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int SEQ_W         = 16
) (
    input  logic           clk,
    input  logic           sys_if_rstn,
    freq_gate_gen_if.slave ctl
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] S_LOAD = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, WINDOW, SETTLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d, wc_q, wc_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             len_ok, req, launch;

    // a window is requested by start in IDLE or by continuous in DONE; zero length turns it into an error
    assign len_ok = ctl.window_len != '0;
    assign req    = (state_q == IDLE && ctl.start) || (state_q == DONE && ctl.continuous);
    assign launch = req && len_ok && !ctl.abort;

    // state and registered outputs; async reset drops the gate without waiting for a clock
    always_ff @(posedge clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            scnt_q  <= '0;
            wc_q    <= '0;
            seq_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            wc_q    <= wc_d;
            seq_q   <= seq_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // next state; abort overrides every forward transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            WINDOW:  state_d = ctl.abort ? IDLE : (wcnt_q == CNT_W'(1) ? SETTLE : WINDOW);
            SETTLE:  state_d = ctl.abort ? IDLE : (scnt_q == SW'(1) ? DONE : SETTLE);
            default: state_d = launch ? WINDOW : IDLE;
        endcase
    end

    // counters and output next values, decoded from the upcoming state so outputs stay registered
    always_comb begin
        wcnt_d = launch ? ctl.window_len : (state_q == WINDOW ? wcnt_q - CNT_W'(1) : wcnt_q);
        scnt_d = (state_q == WINDOW && state_d == SETTLE) ? S_LOAD :
                 (state_q == SETTLE ? scnt_q - SW'(1) : scnt_q);
        wc_d   = launch ? ctl.window_len : wc_q;
        en_d   = state_d == WINDOW;
        busy_d = state_d != IDLE;
        done_d = state_q == SETTLE && state_d == DONE;
        seq_d  = done_d ? seq_q + SEQ_W'(1) : seq_q;
        err_d  = req && !len_ok;
    end

    assign ctl.en_sample     = en_q;
    assign ctl.busy          = busy_q;
    assign ctl.meas_done     = done_q;
    assign ctl.window_cycles = wc_q;
    assign ctl.meas_seq      = seq_q;
    assign ctl.err_zero_len  = err_q;
endmodule
